// File: rtl/bus_transfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_transfer_ctrl_pkg
// Brief    : Shared types, defaults and helpers for the bus transfer sequencer.
// Revision : 1.0  initial release
// ============================================================================
package bus_transfer_ctrl_pkg;

    localparam int c_WIDTH_DEF = 16;
    localparam int c_SEL_W_DEF = 2;
    localparam int c_NREG_DEF  = 4;
    localparam int c_OH_W      = 32;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_DRIVE   = 2'd1;
    localparam logic [1:0] c_ST_LATCH   = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_DRIVE   = c_ST_DRIVE,
        ST_LATCH   = c_ST_LATCH,
        ST_RELEASE = c_ST_RELEASE
    } state_e;

    // Wide one-hot; callers cast down to their own register count.
    function automatic logic [c_OH_W-1:0] onehot(input int unsigned idx);
        onehot = c_OH_W'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_transfer_ctrl
// Brief    : Sequences one register/external move over the shared tri-state
//            bus as DRIVE -> LATCH -> RELEASE strobes with a turnaround cycle.
// Revision : 1.0  initial release
// ============================================================================
module bus_transfer_ctrl
    import bus_transfer_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int NREG  = c_NREG_DEF,
    parameter int SEL_W = c_SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_src,
    input  logic [SEL_W-1:0] req_dst,
    input  logic             req_ext,
    input  logic [WIDTH-1:0] ext_data,
    output logic [NREG-1:0]  R_out,
    output logic [NREG-1:0]  R_in,
    inout  wire  [WIDTH-1:0] bus,
    output logic             done,
    output logic             done_err,
    output logic [WIDTH-1:0] done_data
);

    state_e             r_state_q;
    state_e             w_state_d;
    logic [SEL_W-1:0]   r_dst_q,       w_dst_d;
    logic [WIDTH-1:0]   r_data_q,      w_data_d;
    logic [NREG-1:0]    r_rout_q,      w_rout_d;
    logic [NREG-1:0]    r_rin_q,       w_rin_d;
    logic               r_drive_q,     w_drive_d;
    logic               r_done_q,      w_done_d;
    logic               r_done_err_q,  w_done_err_d;
    logic [WIDTH-1:0]   r_done_data_q, w_done_data_d;
    logic               w_req_bad;

    assign w_req_bad = (int'(req_dst) >= NREG) ||
                       (!req_ext && ((int'(req_src) >= NREG) || (req_src == req_dst)));

    always_comb begin
        w_state_d     = r_state_q;
        w_dst_d       = r_dst_q;
        w_data_d      = r_data_q;
        w_rout_d      = '0;
        w_rin_d       = '0;
        w_drive_d     = 1'b0;
        w_done_d      = 1'b0;
        w_done_err_d  = 1'b0;
        w_done_data_d = r_done_data_q;
        case (r_state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    w_dst_d  = req_dst;
                    w_data_d = ext_data;
                    if (w_req_bad) begin
                        w_state_d    = ST_RELEASE;
                        w_done_d     = 1'b1;
                        w_done_err_d = 1'b1;
                    end else begin
                        w_state_d = ST_DRIVE;
                        w_rout_d  = req_ext ? '0 : NREG'(onehot(int'(req_src)));
                        w_drive_d = req_ext;
                    end
                end
            end
            ST_DRIVE: begin
                w_state_d = ST_LATCH;
                w_rout_d  = r_rout_q;
                w_drive_d = r_drive_q;
                w_rin_d   = NREG'(onehot(int'(r_dst_q)));
            end
            ST_LATCH: begin
                // Destination register loads from the bus on this same edge.
                w_state_d     = ST_RELEASE;
                w_done_d      = 1'b1;
                w_done_data_d = bus;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q     <= ST_IDLE;
            r_dst_q       <= '0;
            r_data_q      <= '0;
            r_rout_q      <= '0;
            r_rin_q       <= '0;
            r_drive_q     <= 1'b0;
            r_done_q      <= 1'b0;
            r_done_err_q  <= 1'b0;
            r_done_data_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_dst_q       <= w_dst_d;
            r_data_q      <= w_data_d;
            r_rout_q      <= w_rout_d;
            r_rin_q       <= w_rin_d;
            r_drive_q     <= w_drive_d;
            r_done_q      <= w_done_d;
            r_done_err_q  <= w_done_err_d;
            r_done_data_q <= w_done_data_d;
        end
    end

    assign req_ready = (r_state_q == ST_IDLE);
    assign R_out     = r_rout_q;
    assign R_in      = r_rin_q;
    assign done      = r_done_q;
    assign done_err  = r_done_err_q;
    assign done_data = r_done_data_q;
    assign bus       = r_drive_q ? r_data_q : {WIDTH{1'bz}};

    a_single_driver: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({r_rout_q, r_drive_q}));
    a_single_load: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(r_rin_q));
    a_load_in_latch: assert property (@(posedge clk) disable iff (!rst)
        (|r_rin_q) |-> (r_state_q == ST_LATCH));
    a_quiet_bus: assert property (@(posedge clk) disable iff (!rst)
        ((r_state_q == ST_IDLE) || (r_state_q == ST_RELEASE)) |-> (!(|r_rout_q) && !r_drive_q));

endmodule
`default_nettype wire
